// File: rtl/product_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one iteration per clock,
// with valid/ready handshakes on the input and output sides.
module product_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   digits_q, digits_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
  logic [BCD_W-1:0]   corrected_s;
  logic [BCD_W-1:0]   shifted_s;

  // Every digit >= 5 gets +3 before the shift; carries out of a digit are dropped.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = d[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = d[4*i +: 4];
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    digits_d    = digits_q;
    cnt_d       = cnt_q;
    out_bcd_d   = out_bcd_q;
    corrected_s = add3_digits(digits_q);
    shifted_s   = {corrected_s[BCD_W-2:0], bin_q[WIDTH-1]};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d    = in_data;
          digits_d = {BCD_W{1'b0}};
          cnt_d    = CNT_W'(WIDTH);
          state_d  = SHIFT;
        end else begin
          state_d  = IDLE;
        end
      end
      SHIFT: begin
        digits_d = shifted_s;
        bin_d    = bin_q << 1'b1;
        cnt_d    = cnt_q - CNT_W'(1);
        // The last iteration publishes its own shifted value, not the stale register.
        if (cnt_q == CNT_W'(1)) begin
          out_bcd_d = shifted_s;
          state_d   = DONE;
        end else begin
          state_d   = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= {WIDTH{1'b0}};
      digits_q  <= {BCD_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      out_bcd_q <= {BCD_W{1'b0}};
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      digits_q  <= digits_d;
      cnt_q     <= cnt_d;
      out_bcd_q <= out_bcd_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_product_to_bcd_seq.sv
// Directed self-checking bench for product_to_bcd_seq with hand-computed BCD results.
module tb_product_to_bcd_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_bcd;
  logic        busy;

  int n_cmp;
  int n_bad;

  product_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Accept one operand with out_ready high, check latency, result and return to IDLE.
  task automatic test_convert(input logic [7:0] v, input logic [11:0] exp, input string name);
    int k;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = v;
    step();
    in_valid  = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_start busy=%b in_ready=%b required busy=1 in_ready=0", name, busy, in_ready);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (k !== 8) begin
      n_bad++;
      $display("FAIL %s_latency got=%0d required=8", name, k);
    end
    n_cmp++;
    if (out_bcd !== exp) begin
      n_bad++;
      $display("FAIL %s_result got=%h required=%h", name, out_bcd, exp);
    end
    step();
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_release in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 12'h000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state ov=%b ir=%b bcd=%h busy=%b required 0/1/000/0",
               out_valid, in_ready, out_bcd, busy);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_out_ready ov=%b ir=%b busy=%b required 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_values();
    test_convert(8'd255, 12'h255, "max255");
    test_convert(8'd0,   12'h000, "zero");
    test_convert(8'd99,  12'h099, "d99");
    test_convert(8'd100, 12'h100, "d100");
  endtask

  task automatic test_backpressure();
    int k;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd63;
    step();
    in_valid  = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_bcd !== 12'h063 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL hold63_cycle%0d ov=%b bcd=%h ir=%b required 1/063/0", c, out_valid, out_bcd, in_ready);
      end
      if (c < 4) step();
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_bcd !== 12'h063) begin
      n_bad++;
      $display("FAIL hold63_release ov=%b ir=%b bcd=%h required 0/1/063", out_valid, in_ready, out_bcd);
    end
  endtask

  task automatic test_ignore_during_shift();
    int k;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd200;
    step();
    in_valid  = 1'b1;
    in_data   = 8'd17;
    for (int c = 0; c < 2; c++) begin
      step();
      n_cmp++;
      if (in_ready !== 1'b0 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL ignore17_cycle%0d ir=%b busy=%b required 0/1", c, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (out_bcd !== 12'h200 || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL ignore17_result got=%h ov=%b required 200/1", out_bcd, out_valid);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int k;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd5;
    step();
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (out_bcd !== 12'h005) begin
      n_bad++;
      $display("FAIL b2b_result got=%h required=005", out_bcd);
    end
    // Consume edge with in_valid still high: must land in IDLE, not SHIFT.
    step();
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_no_same_cycle busy=%b ir=%b required 0/1", busy, in_ready);
    end
    in_data = 8'd42;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_second_accept busy=%b required 1", busy);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (out_bcd !== 12'h042 || k !== 8) begin
      n_bad++;
      $display("FAIL b2b_second got=%h lat=%0d required 042/8", out_bcd, k);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd128;
    step();
    in_valid  = 1'b0;
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_bcd !== 12'h000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid ir=%b ov=%b bcd=%h busy=%b required 1/0/000/0",
               in_ready, out_valid, out_bcd, busy);
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd77;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_vs_accept busy=%b ir=%b required 0/1", busy, in_ready);
    end
    test_convert(8'd128, 12'h128, "fresh128");
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_values();
    test_backpressure();
    test_ignore_during_shift();
    test_back_to_back();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
